// File: rtl/id_grf_pkg.sv
// Shared types and constants for the ID-stage register file and its commit trace.
// The trace entry layout {pc, addr, data} is the 69-bit word stored in the FIFO.
package id_grf_pkg;

    localparam int GRF_ADDR_W      = 5;
    localparam int DATA_W          = 32;
    localparam int NUM_REGS        = 32;
    localparam int TRACE_DEPTH_DEF = 4;

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [GRF_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

    // $0 reads zero; a same-cycle write to the read address is forwarded.
    function automatic logic [DATA_W-1:0] grf_read(
        input logic [GRF_ADDR_W-1:0] raddr,
        input logic                  we,
        input logic [GRF_ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0]     wdata,
        input logic [DATA_W-1:0]     stored
    );
        if (raddr == '0) begin
            return '0;
        end
        if (we && (waddr == raddr)) begin
            return wdata;
        end
        return stored;
    endfunction

endpackage

// File: rtl/id_grf_trace_fifo.sv
// First-word-fall-through FIFO with occupancy count and a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Storage needs no reset: entries are only observable while counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head_data = mem[rd_ptr];
    assign valid     = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/id_grf.sv
// ID-stage MIPS general register file: two bypassed read ports, one WB write port,
// and a commit-trace FIFO recording every WB write (including writes aimed at $0).
module id_grf
    import id_grf_pkg::*;
#(
    parameter int TRACE_DEPTH = TRACE_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          WB_we_ID,
    input  logic [GRF_ADDR_W-1:0]         WB_addr_ID,
    input  logic [DATA_W-1:0]             WB_data_ID,
    input  logic [DATA_W-1:0]             WB_pc_ID,
    input  logic [GRF_ADDR_W-1:0]         ID_rs_addr,
    input  logic [GRF_ADDR_W-1:0]         ID_rt_addr,
    output logic [DATA_W-1:0]             ID_rs_data,
    output logic [DATA_W-1:0]             ID_rt_data,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [DATA_W-1:0]             trace_pc,
    output logic [DATA_W-1:0]             trace_data,
    output logic [GRF_ADDR_W-1:0]         trace_addr,
    output logic [$clog2(TRACE_DEPTH):0]  trace_count,
    output logic                          trace_overflow
);

    logic [DATA_W-1:0]  regs [NUM_REGS];
    trace_entry_t       push_entry;
    trace_entry_t       head_entry;
    logic [TRACE_W-1:0] head_bits;

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_we_ID && (WB_addr_ID != '0)) begin
            regs[WB_addr_ID] <= WB_data_ID;
        end
    end

    assign ID_rs_data = grf_read(ID_rs_addr, WB_we_ID, WB_addr_ID, WB_data_ID, regs[ID_rs_addr]);
    assign ID_rt_data = grf_read(ID_rt_addr, WB_we_ID, WB_addr_ID, WB_data_ID, regs[ID_rt_addr]);

    assign push_entry = '{pc: WB_pc_ID, addr: WB_addr_ID, data: WB_data_ID};

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (WB_we_ID),
        .push_data (push_entry),
        .pop       (trace_ready),
        .head_data (head_bits),
        .valid     (trace_valid),
        .count     (trace_count),
        .overflow  (trace_overflow)
    );

    assign head_entry = trace_entry_t'(head_bits);
    assign trace_pc   = head_entry.pc;
    assign trace_addr = head_entry.addr;
    assign trace_data = head_entry.data;

endmodule

// File: tb/tb_id_grf.sv
// Self-checking bench for id_grf: a register model for the read ports and a
// queue scoreboard of expected trace entries popped as the consumer accepts them.
module tb_id_grf;
    import id_grf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        WB_we_ID;
    logic [4:0]  WB_addr_ID;
    logic [31:0] WB_data_ID;
    logic [31:0] WB_pc_ID;
    logic [4:0]  ID_rs_addr;
    logic [4:0]  ID_rt_addr;
    logic [31:0] ID_rs_data;
    logic [31:0] ID_rt_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_data;
    logic [4:0]  trace_addr;
    logic [2:0]  trace_count;
    logic        trace_overflow;

    int           check_count = 0;
    int           error_count = 0;
    logic [31:0]  reg_model [32];
    trace_entry_t sb_queue [$];
    logic         ovf_model = 1'b0;

    id_grf #(.TRACE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_we_ID       (WB_we_ID),
        .WB_addr_ID     (WB_addr_ID),
        .WB_data_ID     (WB_data_ID),
        .WB_pc_ID       (WB_pc_ID),
        .ID_rs_addr     (ID_rs_addr),
        .ID_rt_addr     (ID_rt_addr),
        .ID_rs_data     (ID_rs_data),
        .ID_rt_data     (ID_rt_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_data     (trace_data),
        .trace_addr     (trace_addr),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] ra, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] r;
        r = reg_model[ra];
        if (we && wa == ra) r = wd;
        if (ra == 5'd0) r = 32'd0;
        return r;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 32; i++) reg_model[i] = 32'd0;
        sb_queue.delete();
        ovf_model = 1'b0;
    endtask

    task automatic checkHead();
        checkOutput("trace_valid", {31'd0, trace_valid}, {31'd0, sb_queue.size() != 0});
        checkOutput("trace_count", {29'd0, trace_count}, sb_queue.size());
        checkOutput("trace_overflow", {31'd0, trace_overflow}, {31'd0, ovf_model});
        if (sb_queue.size() != 0) begin
            checkOutput("head_pc", trace_pc, sb_queue[0].pc);
            checkOutput("head_addr", {27'd0, trace_addr}, {27'd0, sb_queue[0].addr});
            checkOutput("head_data", trace_data, sb_queue[0].data);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data,
                                 input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic ready);
        bit           pop_now;
        trace_entry_t e;
        WB_we_ID    = we;
        WB_addr_ID  = addr;
        WB_data_ID  = data;
        WB_pc_ID    = pc;
        ID_rs_addr  = rs;
        ID_rt_addr  = rt;
        trace_ready = ready;
        #1;
        checkOutput("rs_read", ID_rs_data, expRead(rs, we, addr, data));
        checkOutput("rt_read", ID_rt_data, expRead(rt, we, addr, data));
        pop_now = (sb_queue.size() != 0) && ready;
        @(posedge clk);
        if (pop_now) void'(sb_queue.pop_front());
        if (we) begin
            e.pc = pc;
            e.addr = addr;
            e.data = data;
            if (sb_queue.size() < DEPTH) sb_queue.push_back(e);
            else ovf_model = 1'b1;
            if (addr != 5'd0) reg_model[addr] = data;
        end
        @(negedge clk);
        checkHead();
    endtask

    task automatic drainAll();
        for (int n = 0; n < 20 && sb_queue.size() != 0; n++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        end
        checkOutput("drain_empty", {31'd0, trace_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        WB_we_ID = 1'b0;
        WB_addr_ID = '0;
        WB_data_ID = '0;
        WB_pc_ID = '0;
        ID_rs_addr = '0;
        ID_rt_addr = '0;
        trace_ready = 1'b0;
        resetModel();
        @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            ID_rs_addr = 5'(i);
            ID_rt_addr = 5'(31 - i);
            #1;
            checkOutput("reset_rs", ID_rs_data, 32'd0);
            checkOutput("reset_rt", ID_rt_data, 32'd0);
        end
        checkOutput("reset_valid", {31'd0, trace_valid}, 32'd0);
        checkOutput("reset_count", {29'd0, trace_count}, 32'd0);
        checkOutput("reset_overflow", {31'd0, trace_overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 32'h3000, 5'd5, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5, 1'b0);
        checkOutput("array_r5", ID_rs_data, 32'h1234_5678);

        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 5'd5, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        drainAll();

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i), 32'h4000 + 32'(4 * i), 5'(i), 5'(i - 1), 1'b0);
        end
        checkOutput("full_count", {29'd0, trace_count}, 32'd4);
        checkOutput("full_overflow", {31'd0, trace_overflow}, 32'd1);
        drainAll();

        for (int i = 6; i <= 9; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 32'h5000 + 32'(4 * i), 5'(i), 5'(i), 1'b0);
        end
        applyStimulus(1'b1, 5'd10, 32'h10A, 32'h5028, 5'd9, 5'd10, 1'b1);
        checkOutput("pushpop_count", {29'd0, trace_count}, 32'd4);
        drainAll();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'(11 + i), 32'hA0 + 32'(i), 32'h6000 + 32'(4 * i), 5'(10 + i), 5'(11 + i), 1'b1);
        end
        drainAll();

        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        drainAll();

        // Overflow is sticky here so the asynchronous reset must visibly clear it.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'd20, 32'(i), 32'h7000, 5'd0, 5'd0, 1'b0);
        end
        drainAll();
        applyStimulus(1'b1, 5'd7, 32'h0000_ABCD, 32'h8000, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd8, 32'h0000_0008, 32'h8004, 5'd7, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd9, 32'h0000_0009, 32'h8008, 5'd7, 5'd7, 1'b0);
        checkOutput("pre_reset_r7", ID_rs_data, 32'h0000_ABCD);
        WB_we_ID = 1'b0;
        ID_rs_addr = 5'd7;
        #2;
        rst = 1'b0;
        #1;
        resetModel();
        checkOutput("midrst_valid", {31'd0, trace_valid}, 32'd0);
        checkOutput("midrst_count", {29'd0, trace_count}, 32'd0);
        checkOutput("midrst_overflow", {31'd0, trace_overflow}, 32'd0);
        checkOutput("midrst_r7", ID_rs_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, 5'd3, 32'h0000_0033, 32'h9000, 5'd7, 5'd3, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd7, 1'b1);
        drainAll();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/id_grf.md
# id_grf

General register file at the ID stage: the receiving end of the write-back port driven by the WB stage (`WB_we_ID`, `WB_addr_ID`, `WB_data_ID`, `WB_pc_ID`). It holds the 32×32-bit MIPS GPRs and serves the two ID read ports, with same-cycle write-through bypass. It also records every committed write into a small commit-trace FIFO, drained by a valid/ready consumer (testbench logger or debug port).

## Interface
- `TRACE_DEPTH`, default 4: commit-trace FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `WB_we_ID`  in  1  write enable from WB.
- `WB_addr_ID`  in  5  destination register.
- `WB_data_ID`  in  32  write data.
- `WB_pc_ID`  in  32  PC of the writing instruction.
- `ID_rs_addr`, `ID_rt_addr`  in  5 each  read addresses.
- `ID_rs_data`, `ID_rt_data`  out  32 each  read data (combinational).
- `trace_valid`  out  1  trace head entry valid.
- `trace_ready`  in  1  consumer accepts head.
- `trace_pc`, `trace_data`  out  32 each  head entry PC and data.
- `trace_addr`  out  5  head entry register.
- `trace_count`  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy.
- `trace_overflow`  out  1  sticky: a commit was dropped.

## Operation
- Reset (`rst`=0, asynchronous): all 32 registers ← 0; FIFO emptied; `trace_valid`=0, `trace_count`=0, `trace_overflow`=0. Read outputs then follow the zeroed array.
- Write: on a rising edge with `WB_we_ID`=1 and `WB_addr_ID`≠0, reg[`WB_addr_ID`] ← `WB_data_ID`. Register 0 is never written and always reads 0.
- Read: `ID_xx_data` = 0 if address is 0; else `WB_data_ID` if `WB_we_ID`=1 and `WB_addr_ID` equals the read address (bypass); else reg[address]. Both ports are independent and may hit the same or different registers.
- Trace push: every cycle with `WB_we_ID`=1 pushes {`WB_pc_ID`, `WB_addr_ID`, `WB_data_ID`}. Writes to $0 are also traced, with data as supplied; this keeps the trace aligned with WB commits.
- Trace pop: on a rising edge with `trace_valid`=1 and `trace_ready`=1.
- Head presentation: first-word-fall-through. The head is visible while `trace_valid`=1 and stays stable until it is popped.
- Full FIFO plus push:
  - With a pop in the same cycle, the push is accepted and the count is unchanged.
  - With no pop, the new entry is dropped, existing entries are untouched, and `trace_overflow` ← 1.
  - `trace_overflow` stays at 1 until reset.
- Empty FIFO plus push and `trace_ready`=1 in the same cycle: no pop (`trace_valid` was 0). The entry appears on the next cycle.
- Pointers are log2(TRACE_DEPTH) bits and wrap modulo the depth. The count is kept separately so that full and empty can be told apart.

## Timing
- Register write latency: 1 edge. A read in the same cycle as the write sees the new value via bypass; later cycles see it from the array.
- Trace latency: push at edge N gives `trace_valid`=1 after edge N when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- `trace_count` changes only on rising edges or on reset:
  - +1 on push only.
  - −1 on pop only.
  - 0 on push+pop.
  - 0 on a dropped push to a full FIFO with no pop.
- Reset asserted mid-operation clears everything immediately. Pending WB inputs are ignored while `rst`=0.
- The read path is purely combinational from `ID_*_addr`, `WB_*` and the array; no other outputs are combinational from inputs.

## Structure
- `const.v` gains `` `GRF_ADDR_W `` (5) and `` `TRACE_DEPTH_DEF `` (4). The existing instruction-field macros stay there.
- Sub-module `trace_fifo` (parameterised depth/width, FWFT, push/pop, count, overflow). It is instantiated with a width of 69 bits ({pc, addr, data}).
- The register array, bypass muxes and $0 handling live in `id_grf` itself.

## Test plan
- Reset then read all 32 addresses → all 0; `trace_valid`=0, `trace_count`=0, `trace_overflow`=0.
- Write $5←0x1234_5678 at PC 0x3000 with `ID_rs_addr`=5 in the same cycle:
  - that cycle, `ID_rs_data`=0x1234_5678 (bypass);
  - next cycle, still 0x1234_5678 from the array;
  - trace head = {0x3000, 5, 0x1234_5678}.
- Write $0←0xFFFF_FFFF → `ID_rt_data` with `ID_rt_addr`=0 reads 0 in that cycle and after; trace entry {pc, 0, 0xFFFF_FFFF} is present.
- `trace_ready`=0, five consecutive writes ($1..$5, data 1..5) → `trace_count`=4, `trace_overflow`=1; draining yields data 1, 2, 3, 4 only.
- FIFO full, push and pop in the same cycle → count stays 4, no overflow, order preserved. With `trace_ready`=1 continuously for 8 writes → count ≤1 and entries emerge in order.
- Assert `rst`=0 mid-stream with 3 entries queued and $7=0xABCD → immediately `trace_valid`=0, `trace_count`=0, and $7 reads 0.
